rotate_cmd_sequencer: RTL and testbench

//  Command-level controller for the WIDTH-bit rotation register. Accepts LOAD/ROTATE/READ commands

---
 rtl/rot_pkg.sv | 31 +++
 rtl/rot_step_counter.sv | 40 ++++
 rtl/rotate_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rotate_cmd_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation-register command sequencer.
package rot_pkg;

  // Host command opcodes
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_ROT_L = 2'd1,
    OP_ROT_R = 2'd2,
    OP_READ  = 2'd3
  } rot_op_e;

  // Direction codes driven to the rotation register
  localparam logic [1:0] DIR_LOAD  = 2'b00;
  localparam logic [1:0] DIR_ROT_L = 2'b01;
  localparam logic [1:0] DIR_ROT_R = 2'b10;
  localparam logic [1:0] DIR_HOLD  = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_e;

  // Direction code for a rotate opcode
  function automatic logic [1:0] rot_dir(input rot_op_e op);
    return (op == OP_ROT_L) ? DIR_ROT_L : DIR_ROT_R;
  endfunction

endpackage

// File: rtl/rot_step_counter.sv
// Rotate step counter: loads the step count, decrements while enabled,
// and flags the cycle on which the final step is being driven.
module rot_step_counter #(
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             last_q;

  // Next count: load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = amt_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - AMT_W'(1);
    end
  end

  // Count register; last flag is registered so it is valid for the whole cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= (cnt_d == AMT_W'(1));
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/rotate_cmd_sequencer.sv
// Command-level controller for the rotation register: accepts LOAD/ROTATE/READ
// commands, drives the register direction code, and returns its contents.
module rotate_cmd_sequencer
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       reg_dir,
  output logic [WIDTH-1:0] reg_din,
  input  logic [WIDTH-1:0] reg_dout,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  rot_op_e          op_q, op_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic [1:0]       dir_q, dir_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             cnt_load, cnt_en, cnt_last;

  // Register contents after one more step in the given direction
  function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] v, input rot_op_e op);
    if (op == OP_ROT_L) begin
      return {v[WIDTH-2:0], v[WIDTH-1]};
    end
    return {v[0], v[WIDTH-1:1]};
  endfunction

  rot_step_counter #(
    .AMT_W (AMT_W)
  ) u_step_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .amt_i  (cmd_amt),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  // Next-state and registered-output logic. rsp_data is captured on the edge
  // that enters RESP as the value the register holds after that same edge.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = rot_op_e'(cmd_op);
          din_d = cmd_data;
          unique case (rot_op_e'(cmd_op))
            OP_LOAD: state_d = ST_LOAD;
            OP_ROT_L, OP_ROT_R: begin
              if (cmd_amt >= AMT_W'(WIDTH)) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = reg_dout;
              end else if (cmd_amt == '0) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = reg_dout;
              end else begin
                state_d  = ST_ROTATE;
                cnt_load = 1'b1;
              end
            end
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_data_d  = reg_dout;
            end
          endcase
        end
      end
      ST_LOAD: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = din_q;
      end
      ST_ROTATE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = step_once(reg_dout, op_q);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    unique case (state_d)
      ST_LOAD:   dir_d = DIR_LOAD;
      ST_ROTATE: dir_d = rot_dir(op_d);
      default:   dir_d = DIR_HOLD;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      din_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      dir_q       <= DIR_HOLD;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      din_q       <= din_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign reg_dir   = dir_q;
  assign reg_din   = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Scoreboard bench for rotate_cmd_sequencer with a behavioural rotation register.
module tb_rotate_cmd_sequencer;

  localparam int unsigned W  = 100;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic [W-1:0]  rsp_data;
  logic [1:0]    reg_dir;
  logic [W-1:0]  reg_din;
  logic [W-1:0]  reg_dout;
  logic          busy;

  logic [W-1:0] rreg = '0;
  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  rotate_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .reg_dir   (reg_dir),
    .reg_din   (reg_din),
    .reg_dout  (reg_dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural rotation register (no reset of its own)
  always @(posedge clk) begin
    case (reg_dir)
      2'b00:   rreg <= reg_din;
      2'b01:   rreg <= {rreg[W-2:0], rreg[W-1]};
      2'b10:   rreg <= {rreg[0], rreg[W-1:1]};
      default: rreg <= rreg;
    endcase
  end
  assign reg_dout = rreg;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, track latency and register activity until rsp_valid
  task automatic issue(input string name, input logic [1:0] op, input logic [AW-1:0] amt,
                       input logic [W-1:0] data, input logic exp_err, input logic [W-1:0] exp_data,
                       input int exp_lat, input int exp_act, input logic [1:0] exp_dir);
    int lat, act, wrong, g;
    sb_q.push_back('{err: exp_err, data: exp_data});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; act = 0; wrong = 0;
    do begin
      @(negedge clk);
      lat++;
      if (reg_dir != 2'b11) begin
        act++;
        if (reg_dir != exp_dir) wrong++;
      end
    end while (!rsp_valid && lat < 300);
    chk({name, "_latency"}, W'(lat), W'(exp_lat));
    chk({name, "_dir_cycles"}, W'(act), W'(exp_act));
    chk({name, "_dir_code"}, W'(wrong), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_amt = '0; cmd_data = '0; rsp_ready = 1'b1;
    fork
      // Monitor: compare every accepted response against the scoreboard
      forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", W'(rsp_err), W'(e.err));
          end
        end
      end
      begin : stim
        logic [W-1:0] held;
        int bad_rdy, bad_dir, bad_dat, no_val, g, lat, act;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", W'(cmd_ready), W'(1));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_rsp_err", W'(rsp_err), W'(0));
        chk("rst_rsp_data", rsp_data, W'(0));
        chk("rst_reg_dir", W'(reg_dir), W'(2'b11));
        chk("rst_reg_din", reg_din, W'(0));
        chk("rst_busy", W'(busy), W'(0));
        #20;
        @(negedge clk) rst_n = 1'b1;

        issue("load1", 2'd0, 8'd0, 100'h1, 1'b0, 100'h1, 2, 1, 2'b00);
        issue("rotl3", 2'd1, 8'd3, '0, 1'b0, 100'h8, 4, 3, 2'b01);
        issue("load1b", 2'd0, 8'd0, 100'h1, 1'b0, 100'h1, 2, 1, 2'b00);
        issue("rotr1", 2'd2, 8'd1, '0, 1'b0, 100'h1 << 99, 2, 1, 2'b10);
        issue("load1c", 2'd0, 8'd0, 100'h1, 1'b0, 100'h1, 2, 1, 2'b00);
        issue("rotl99", 2'd1, 8'd99, '0, 1'b0, 100'h1 << 99, 100, 99, 2'b01);
        issue("rotl100", 2'd1, 8'd100, '0, 1'b1, 100'h1 << 99, 1, 0, 2'b11);
        issue("rotl255", 2'd1, 8'd255, '0, 1'b1, 100'h1 << 99, 1, 0, 2'b11);
        issue("rotr0", 2'd2, 8'd0, '0, 1'b0, 100'h1 << 99, 1, 0, 2'b11);
        issue("loada5", 2'd0, 8'd0, 100'hA5, 1'b0, 100'hA5, 2, 1, 2'b00);
        issue("rotr4", 2'd2, 8'd4, '0, 1'b0, (100'h5 << 96) | 100'hA, 5, 4, 2'b10);

        // Back-pressure: READ held in RESP while a second command waits
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        sb_q.push_back('{err: 1'b0, data: (100'h5 << 96) | 100'hA});
        sb_q.push_back('{err: 1'b0, data: (100'h5 << 95) | 100'h5});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_amt = '0;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 begin cmd_op = 2'd2; cmd_amt = 8'd1; end
        bad_rdy = 0; bad_dir = 0; bad_dat = 0; no_val = 0;
        @(negedge clk);
        held = rsp_data;
        repeat (10) begin
          if (cmd_ready) bad_rdy++;
          if (reg_dir != 2'b11) bad_dir++;
          if (rsp_data !== held) bad_dat++;
          if (!rsp_valid) no_val++;
          @(negedge clk);
        end
        chk("bp_cmd_ready_low", W'(bad_rdy), W'(0));
        chk("bp_reg_dir_hold", W'(bad_dir), W'(0));
        chk("bp_rsp_data_stable", W'(bad_dat), W'(0));
        chk("bp_rsp_valid_high", W'(no_val), W'(0));
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        chk("bp_second_after_handshake", W'(sb_q.size()), W'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; act = 0;
        do begin
          @(negedge clk);
          lat++;
          if (reg_dir == 2'b10) act++;
        end while (!rsp_valid && lat < 300);
        chk("bp_rotr1_latency", W'(lat), W'(2));
        chk("bp_rotr1_dir_cycles", W'(act), W'(1));

        // Reset in the middle of a 50-step rotation
        issue("load1d", 2'd0, 8'd0, 100'h1, 1'b0, 100'h1, 2, 1, 2'b00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_amt = 8'd50;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rot_dir", W'(reg_dir), W'(2'b01));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_reg_dir", W'(reg_dir), W'(2'b11));
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_cmd_ready", W'(cmd_ready), W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("read_after_rst", 2'd3, 8'd0, '0, 1'b0, 100'h1 << 20, 1, 0, 2'b11);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", W'(sb_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join_any
  end

endmodule
